uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte sources using round-robin arbitration.
- Accepts a byte from each requester with a valid/ready handshake and issues a one-cycle transmit pulse to the serializer.
- Tracks the serializer's busy output through one full frame, then returns to arbitration.
- Sits between the per-source byte producers and the single uart_tx instance driving the serial pin.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- GAP_CYCLES, 0: idle clk cycles inserted after each frame before the next arbitration, 0..65535.
- ACK_TIMEOUT, 4: cycles to wait for tx_busy to rise after tx_start before flagging an error, 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]
- req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both high
- port_en  in  NUM_REQ  per-requester enable mask; a disabled port is never granted
- tx_start  out  1  one-cycle transmit pulse to the serializer
- tx_data  out  8  byte to the serializer, held stable from tx_start until the frame completes
- tx_busy  in  1  busy output of the serializer
- grant_id  out  $clog2(NUM_REQ)  index of the requester owning the current frame
- active  out  1  high in every state except IDLE
- err_timeout  out  1  sticky; set when tx_busy fails to rise; cleared only by rst

Behaviour:
- Clock and reset: single clock, clk; rst is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, tx_start=0, tx_data=0, grant_id=0, err_timeout=0.
  - req_ready=0, active=0, gap counter=0, timeout counter=0.
- States: IDLE, START, WAIT_HI, WAIT_LO, GAP.
- IDLE, arbitration:
  - Eligible set is req_valid & port_en.
  - Grant goes to the first eligible index found searching upward from rr_ptr, with wrap-around.
  - req_ready is combinational: asserted for the granted index only, and only while state==IDLE and tx_busy==0.
  - All other req_ready bits are 0.
- IDLE, on a transfer to index g (same cycle as the handshake):
  - tx_data<=req_data[g], grant_id<=g, rr_ptr<=(g+1) mod NUM_REQ.
  - Next state is START.
- IDLE, no eligible requester: stay in IDLE; rr_ptr is unchanged.
- START: tx_start=1 for exactly this one cycle. Next state is WAIT_HI and the timeout counter is cleared.
- WAIT_HI:
  - If tx_busy=1, go to WAIT_LO.
  - Otherwise increment the counter. When it reaches ACK_TIMEOUT, set err_timeout=1 and go to IDLE.
  - The serializer registers busy, so in normal operation busy is high in the first WAIT_HI cycle.
- WAIT_LO:
  - If tx_busy=0, go to GAP when GAP_CYCLES>0 (counter loaded with GAP_CYCLES-1), otherwise go to IDLE.
- GAP: decrement the counter; when it reaches 0, go to IDLE.
- Latency:
  - Handshake cycle T, tx_start at T+1, tx_busy seen high at T+2.
  - With GAP_CYCLES=0, the next grant is possible in the first cycle after tx_busy is observed low.
- Boundary conditions:
  - Simultaneous requests: exactly one grant per frame; the others wait with valid held. Sources must not drop req_valid without a transfer.
  - A port_en bit dropping mid-frame does not affect the frame in flight.
  - tx_busy high while in IDLE (serializer still draining): no grant.
  - rst mid-frame: the arbiter returns to IDLE immediately and tx_start stays 0. The serializer is reset by its own reset.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - All-ones or all-zero eligible vectors are legal.
- Fairness: with all requesters continuously eligible, grants cycle 0,1,..,NUM_REQ-1,0,...

Decomposition:
- Shared package uart_pkg:
  - arb_state_t enum, 3 bits.
  - Helper function for the next-grant index, rotate-and-priority-encode.
- One natural sub-module, rr_arbiter: purely combinational, taking the eligible vector and rr_ptr and producing grant_valid and grant_idx.
- The FSM, counters and data register stay in uart_tx_arbiter.

Test Plan:
- Single requester: NUM_REQ=4, req_valid=4'b0010, req_data[15:8]=8'hA5, tx_busy modelled by a real uart_tx.
  - Expect req_ready[1] high one cycle, grant_id=1, tx_start one pulse, tx_data=8'hA5 held until tx_busy falls.
  - Expect the serial line to carry a start bit, then 0xA5 LSB first, then a stop bit.
- All four requesters continuously valid with bytes 8'h10, 8'h11, 8'h12, 8'h13:
  - Expect grant order 0,1,2,3,0 and exactly one tx_start per frame.
  - Expect no req_ready asserted while active=1.
- port_en=4'b1011 with all valid: expect grant order 0,1,3,0 and port 2 never readied.
- tx_busy tied 0 with ACK_TIMEOUT=4: after a request is accepted, expect err_timeout=1 exactly 4 cycles after WAIT_HI is entered, then return to IDLE.
- GAP_CYCLES=3 with back-to-back requests: expect exactly 3 cycles of state GAP between tx_busy falling and the next req_ready.
- rst pulsed during WAIT_LO: expect state IDLE, err_timeout=0, rr_ptr=0 and tx_start=0 on the next cycle, and the next grant going to the lowest eligible index.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit arbiter.
//   arb_state_t : arbiter FSM state encoding (3 bits)
//   MAX_REQ     : largest requester count the helper supports
//   next_grant  : rotate-and-priority-encode; returns {found, index}
package uart_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_GAP     = 3'd4
  } arb_state_t;

  // Scan the eligible vector starting at ptr and wrapping at n; the first
  // set bit wins. Bits at or above n are ignored.
  function automatic logic [3:0] next_grant(input logic [MAX_REQ-1:0] elig,
                                            input logic [2:0]         ptr,
                                            input int                 n);
    logic       found;
    logic [2:0] idx;
    int         pos;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= n) pos = pos - n;
      if (k < n && !found && elig[pos[2:0]]) begin
        found = 1'b1;
        idx   = pos[2:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant selection.
//   elig        in  NUM_REQ  eligible requesters (valid & enabled)
//   rr_ptr      in  IDX_W    index with highest priority this round
//   grant_valid out 1        at least one requester is eligible
//   grant_idx   out IDX_W    winning requester index
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [MAX_REQ-1:0] elig_ext;
  logic [2:0]         ptr_ext;
  logic [3:0]         grant_vec;

  // Widen the inputs to the fixed width the package helper works on.
  generate
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_elig
      if (gi < NUM_REQ) begin : g_used
        assign elig_ext[gi] = elig[gi];
      end else begin : g_pad
        assign elig_ext[gi] = 1'b0;
      end
    end
    for (genvar gi = 0; gi < 3; gi++) begin : g_ptr
      if (gi < IDX_W) begin : g_used
        assign ptr_ext[gi] = rr_ptr[gi];
      end else begin : g_pad
        assign ptr_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign grant_vec   = next_grant(elig_ext, ptr_ext, NUM_REQ);
  assign grant_valid = grant_vec[3];
  assign grant_idx   = grant_vec[IDX_W-1:0];

  // Index bits above IDX_W are always zero for a valid NUM_REQ.
  generate
    if (IDX_W < 3) begin : g_hi
      logic unused_hi_bits;
      assign unused_hi_bits = ^grant_vec[2:IDX_W];
    end
  endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between NUM_REQ byte
// sources with round-robin arbitration and frame tracking.
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester byte valid
//   req_data     : byte i at [8i+7:8i]
//   req_ready    : per-requester accept (combinational, granted index only)
//   port_en      : per-requester enable mask
//   tx_start     : one-cycle transmit pulse to the serializer
//   tx_data      : byte to the serializer, held for the whole frame
//   tx_busy      : serializer busy
//   grant_id     : requester owning the current frame
//   active       : high in every state except IDLE
//   err_timeout  : sticky; tx_busy never rose after tx_start
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         port_en,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] grant_id_reg;
  logic [7:0]       tx_data_reg;
  logic             tx_start_reg;
  logic             active_reg;
  logic             err_reg;
  logic [15:0]      gap_cnt_reg;
  logic [7:0]       to_cnt_reg;

  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             ready_en;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .elig        (req_valid & port_en),
    .rr_ptr      (rr_ptr_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // A grant is only offered while idle and the serializer has drained;
  // holding it off during rst keeps req_ready at 0 through reset.
  assign ready_en = (state_reg == ST_IDLE) && !tx_busy && grant_valid && !rst;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = ready_en && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      tx_data_reg  <= 8'h00;
      tx_start_reg <= 1'b0;
      active_reg   <= 1'b0;
      err_reg      <= 1'b0;
      gap_cnt_reg  <= 16'd0;
      to_cnt_reg   <= 8'd0;
    end else begin
      tx_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // ready_en already implies valid & ready for grant_idx.
          if (ready_en) begin
            tx_data_reg  <= req_data[{grant_idx, 3'b000} +: 8];
            grant_id_reg <= grant_idx;
            rr_ptr_reg   <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            tx_start_reg <= 1'b1;
            active_reg   <= 1'b1;
            state_reg    <= ST_START;
          end
        end
        ST_START: begin
          to_cnt_reg <= 8'd0;
          state_reg  <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_busy) begin
            state_reg <= ST_WAIT_LO;
          end else begin
            to_cnt_reg <= to_cnt_reg + 8'd1;
            // Counter reaching ACK_TIMEOUT on this increment ends the wait.
            if (to_cnt_reg == 8'(ACK_TIMEOUT-1)) begin
              err_reg    <= 1'b1;
              active_reg <= 1'b0;
              state_reg  <= ST_IDLE;
            end
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt_reg <= 16'(GAP_CYCLES-1);
              state_reg   <= ST_GAP;
            end else begin
              active_reg <= 1'b0;
              state_reg  <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == 16'd0) begin
            active_reg <= 1'b0;
            state_reg  <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 16'd1;
          end
        end
        default: begin
          active_reg <= 1'b0;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_start    = tx_start_reg;
  assign tx_data     = tx_data_reg;
  assign grant_id    = grant_id_reg;
  assign active      = active_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (no gap / three-cycle gap), each
// driving a behavioural UART serializer with a registered busy output.
module tb_uart_tx_arbiter;

  localparam int BAUD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  valid0 = '0, en0 = '0, ready0;
  logic [31:0] data0 = '0;
  logic        start0, busy_to0, active0, err0;
  logic [7:0]  txd0;
  logic [1:0]  gid0;
  logic        kill0 = 1'b0, force0 = 1'b0;

  logic [3:0]  valid1 = '0, en1 = '0, ready1;
  logic [31:0] data1 = '0;
  logic        start1, busy_to1, active1, err1;
  logic [7:0]  txd1;
  logic [1:0]  gid1;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .ACK_TIMEOUT(4)) dut0 (
    .clk(clk), .rst(rst), .req_valid(valid0), .req_data(data0), .req_ready(ready0),
    .port_en(en0), .tx_start(start0), .tx_data(txd0), .tx_busy(busy_to0),
    .grant_id(gid0), .active(active0), .err_timeout(err0));

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3), .ACK_TIMEOUT(4)) dut1 (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_data(data1), .req_ready(ready1),
    .port_en(en1), .tx_start(start1), .tx_data(txd1), .tx_busy(busy_to1),
    .grant_id(gid1), .active(active1), .err_timeout(err1));

  // Behavioural serializer: start bit, 8 data bits LSB first, stop bit,
  // BAUD clocks per bit, busy registered one cycle after tx_start.
  logic       ser_busy [2];
  logic [9:0] ser_sh   [2];
  int         ser_div  [2];
  int         ser_bit  [2];
  logic [7:0] ser_data [2];
  logic [1:0] ser_start;
  logic       line0;

  assign ser_data[0] = txd0;
  assign ser_data[1] = txd1;
  assign ser_start   = {start1, start0 & ~kill0};
  assign busy_to0    = kill0 ? 1'b0 : (force0 ? 1'b1 : ser_busy[0]);
  assign busy_to1    = ser_busy[1];
  assign line0       = ser_busy[0] ? ser_sh[0][0] : 1'b1;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ser_busy[k] <= 1'b0; ser_div[k] <= 0; ser_bit[k] <= 0; ser_sh[k] <= '1;
      end else if (!ser_busy[k]) begin
        if (ser_start[k]) begin
          ser_busy[k] <= 1'b1; ser_sh[k] <= {1'b1, ser_data[k], 1'b0};
          ser_div[k] <= 0; ser_bit[k] <= 0;
        end
      end else if (ser_div[k] == BAUD-1) begin
        ser_div[k] <= 0;
        if (ser_bit[k] == 9) ser_busy[k] <= 1'b0;
        else begin ser_bit[k] <= ser_bit[k] + 1; ser_sh[k] <= ser_sh[k] >> 1; end
      end else begin
        ser_div[k] <= ser_div[k] + 1;
      end
    end
  end

  // Reference round-robin rule: first eligible index at or after ptr, wrapping.
  function automatic int pick(input logic [3:0] e, input int ptr);
    for (int k = 0; k < 4; k++) if (e[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic do_reset;
    rst = 1'b1; valid0 = '0; valid1 = '0; kill0 = 1'b0; force0 = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for any req_ready on dut0; returns the readied index.
  task automatic wait_hs0(output int g, output bit ok);
    ok = 1'b0; g = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (ready0 != 4'b0) begin
        ok = 1'b1;
        for (int k = 0; k < 4; k++) if (ready0[k]) g = k;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle0;
    for (int i = 0; i < 200 && active0; i++) @(negedge clk);
    n_checks++; if (active0 !== 1'b0) $display("FAIL idle_wait got active=%b want 0", active0); else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid0 = 4'hF; en0 = 4'hF; valid1 = 4'hF; en1 = 4'hF;
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (ready0 !== 4'h0)  $display("FAIL rst_ready got %b want 0000", ready0); else n_pass++;
    n_checks++; if (start0 !== 1'b0)  $display("FAIL rst_start got %b want 0", start0); else n_pass++;
    n_checks++; if (txd0 !== 8'h00)   $display("FAIL rst_txdata got %h want 00", txd0); else n_pass++;
    n_checks++; if (gid0 !== 2'd0)    $display("FAIL rst_grant got %0d want 0", gid0); else n_pass++;
    n_checks++; if (active0 !== 1'b0) $display("FAIL rst_active got %b want 0", active0); else n_pass++;
    n_checks++; if (err0 !== 1'b0)    $display("FAIL rst_err got %b want 0", err0); else n_pass++;
    n_checks++; if (ready1 !== 4'h0 || active1 !== 1'b0) $display("FAIL rst_dut1 got ready=%b active=%b want 0000/0", ready1, active1); else n_pass++;
    rst = 1'b0; valid0 = '0; valid1 = '0;
    $display("reset: outputs sampled under rst");
  endtask

  task automatic test_single;
    int g; bit ok; logic [9:0] frame; int c; int nbits;
    do_reset;
    en0 = 4'hF; data0 = $urandom; data0[15:8] = 8'hA5; valid0 = 4'b0010;
    frame = {1'b1, 8'hA5, 1'b0};
    wait_hs0(g, ok);
    n_checks++; if (!ok || ready0 !== 4'b0010) $display("FAIL single_ready got %b want 0010", ready0); else n_pass++;
    @(negedge clk); valid0 = '0;
    n_checks++; if (start0 !== 1'b1) $display("FAIL single_start got %b want 1", start0); else n_pass++;
    n_checks++; if (gid0 !== 2'd1)   $display("FAIL single_grant got %0d want 1", gid0); else n_pass++;
    n_checks++; if (txd0 !== 8'hA5)  $display("FAIL single_data got %h want a5", txd0); else n_pass++;
    n_checks++; if (active0 !== 1'b1 || ready0 !== 4'h0) $display("FAIL single_active got active=%b ready=%b want 1/0000", active0, ready0); else n_pass++;
    @(negedge clk);
    n_checks++; if (start0 !== 1'b0 || busy_to0 !== 1'b1) $display("FAIL single_pulse got start=%b busy=%b want 0/1", start0, busy_to0); else n_pass++;
    c = 0; nbits = 0;
    while (busy_to0 && c < 100) begin
      n_checks++; if (txd0 !== 8'hA5 || start0 !== 1'b0) $display("FAIL single_hold cyc %0d got data=%h start=%b want a5/0", c, txd0, start0); else n_pass++;
      if (c % BAUD == BAUD/2 && nbits < 10) begin
        n_checks++; if (line0 !== frame[nbits]) $display("FAIL single_line bit %0d got %b want %b", nbits, line0, frame[nbits]); else n_pass++;
        nbits++;
      end
      @(negedge clk); c++;
    end
    n_checks++; if (nbits !== 10 || c !== 10*BAUD) $display("FAIL single_frame got bits=%0d cycles=%0d want 10/%0d", nbits, c, 10*BAUD); else n_pass++;
    $display("single: port 1 byte a5 framed over %0d cycles", c);
    wait_idle0;
  endtask

  task automatic test_round_robin;
    int g, exp, ptr, starts; bit ok;
    do_reset;
    en0 = 4'hF; data0 = {8'h13, 8'h12, 8'h11, 8'h10}; valid0 = 4'hF; ptr = 0;
    for (int f = 0; f < 5; f++) begin
      wait_hs0(g, ok);
      n_checks++; if (!ok) begin $display("FAIL rr_handshake frame %0d got none want grant", f); return; end else n_pass++;
      exp = pick(valid0 & en0, ptr); ptr = (exp + 1) % 4;
      n_checks++; if (g !== exp || ready0 !== (4'b1 << exp)) $display("FAIL rr_grant frame %0d got %b want idx %0d", f, ready0, exp); else n_pass++;
      @(negedge clk);
      if (f == 4) valid0 = '0;
      n_checks++; if (start0 !== 1'b1 || gid0 !== 2'(exp) || txd0 !== 8'h10 + 8'(exp)) $display("FAIL rr_tx frame %0d got start=%b id=%0d data=%h want 1/%0d/%h", f, start0, gid0, txd0, exp, 8'h10 + 8'(exp)); else n_pass++;
      $display("rr: frame %0d granted port %0d byte %h", f, gid0, txd0);
      starts = 1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (start0) starts++;
        if (active0 && ready0 != 4'h0) begin n_checks++; $display("FAIL rr_ready_while_active got %b want 0000", ready0); end
        if (!active0) break;
      end
      n_checks++; if (starts !== 1) $display("FAIL rr_starts frame %0d got %0d want 1", f, starts); else n_pass++;
    end
  endtask

  task automatic test_port_mask;
    int g, exp, ptr; bit ok; int order[4];
    do_reset;
    en0 = 4'b1011; data0 = $urandom; valid0 = 4'hF; ptr = 0;
    order = '{0, 1, 3, 0};
    for (int f = 0; f < 4; f++) begin
      wait_hs0(g, ok);
      exp = pick(valid0 & en0, ptr); ptr = (exp + 1) % 4;
      n_checks++; if (!ok || g !== exp || g !== order[f]) $display("FAIL mask_grant frame %0d got %0d want %0d", f, g, order[f]); else n_pass++;
      @(negedge clk);
      if (f == 3) valid0 = '0;
      $display("mask: frame %0d granted port %0d", f, gid0);
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (ready0[2]) begin n_checks++; $display("FAIL mask_port2_ready got %b want x0xx", ready0); end
        if (!active0) break;
      end
    end
    wait_idle0;
  endtask

  // Randomised traffic against a frame-level model: a grant is possible
  // only between frames, a frame ends the cycle the serializer goes idle.
  task automatic test_random;
    logic [3:0] pend, elig, exp_ready;
    logic [7:0] bytes [4];
    bit         m_free, m_seen, exp_start;
    int         m_ptr, m_g, g, frames;
    logic [7:0] m_byte;
    do_reset;
    pend = '0; m_free = 1'b1; m_seen = 1'b0; exp_start = 1'b0;
    m_ptr = 0; m_g = 0; m_byte = 8'h00; frames = 0;
    for (int k = 0; k < 4; k++) bytes[k] = 8'h00;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < 4; k++)
        if (!pend[k] && $urandom_range(0, 2) == 0) begin pend[k] = 1'b1; bytes[k] = 8'($urandom); end
      valid0 = pend;
      data0  = {bytes[3], bytes[2], bytes[1], bytes[0]};
      en0    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      #1;
      elig = valid0 & en0;
      n_checks++; if (active0 !== !m_free) $display("FAIL rnd_active cyc %0d got %b want %b", cyc, active0, !m_free); else n_pass++;
      n_checks++; if (start0 !== exp_start) $display("FAIL rnd_start cyc %0d got %b want %b", cyc, start0, exp_start); else n_pass++;
      if (!m_free) begin
        n_checks++; if (txd0 !== m_byte || gid0 !== 2'(m_g)) $display("FAIL rnd_hold cyc %0d got %h/%0d want %h/%0d", cyc, txd0, gid0, m_byte, m_g); else n_pass++;
      end
      exp_ready = (m_free && !busy_to0 && elig != 4'h0) ? (4'b1 << pick(elig, m_ptr)) : 4'h0;
      n_checks++; if (ready0 !== exp_ready) $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, ready0, exp_ready); else n_pass++;
      exp_start = 1'b0;
      if (exp_ready != 4'h0) begin
        g = pick(elig, m_ptr);
        m_g = g; m_byte = bytes[g]; pend[g] = 1'b0; m_ptr = (g + 1) % 4;
        m_free = 1'b0; m_seen = 1'b0; exp_start = 1'b1; frames++;
        $display("rnd: transfer %0d port %0d byte %h", frames, g, m_byte);
      end else if (!m_free) begin
        if (busy_to0) m_seen = 1'b1;
        else if (m_seen) m_free = 1'b1;
      end
      @(negedge clk);
    end
    valid0 = '0; en0 = 4'hF;
    wait_idle0;
  endtask

  task automatic test_busy_idle;
    do_reset;
    en0 = 4'hF; data0 = $urandom; force0 = 1'b1; valid0 = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (ready0 !== 4'h0 || active0 !== 1'b0) $display("FAIL busyidle_hold cyc %0d got ready=%b active=%b want 0000/0", i, ready0, active0); else n_pass++;
      @(negedge clk);
    end
    force0 = 1'b0; #1;
    n_checks++; if (ready0 !== 4'b0001) $display("FAIL busyidle_release got %b want 0001", ready0); else n_pass++;
    $display("busy_idle: grant withheld 4 cycles then port 0 readied");
    @(negedge clk); valid0 = '0;
    wait_idle0;
  endtask

  task automatic test_timeout;
    int g; bit ok;
    kill0 = 1'b1; en0 = 4'hF; valid0 = 4'b0001;
    wait_hs0(g, ok);
    n_checks++; if (!ok || g !== 0) $display("FAIL to_handshake got %0d want 0", g); else n_pass++;
    @(negedge clk); valid0 = '0;
    n_checks++; if (start0 !== 1'b1) $display("FAIL to_start got %b want 1", start0); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (err0 !== 1'b0 || active0 !== 1'b1) $display("FAIL to_early waithi cyc %0d got err=%b active=%b want 0/1", c, err0, active0); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (err0 !== 1'b1 || active0 !== 1'b0) $display("FAIL to_flag got err=%b active=%b want 1/0", err0, active0); else n_pass++;
    kill0 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (err0 !== 1'b1) $display("FAIL to_sticky got %b want 1", err0); else n_pass++;
    $display("timeout: err_timeout raised 4 cycles into WAIT_HI");
  endtask

  task automatic test_rst_mid_frame;
    int g; bit ok;
    en0 = 4'hF; valid0 = 4'b0100; data0 = $urandom;
    wait_hs0(g, ok);
    n_checks++; if (!ok || g !== 2) $display("FAIL rstmid_grant got %0d want 2", g); else n_pass++;
    @(negedge clk); valid0 = '0;
    repeat (12) @(negedge clk);
    n_checks++; if (busy_to0 !== 1'b1 || active0 !== 1'b1) $display("FAIL rstmid_inframe got busy=%b active=%b want 1/1", busy_to0, active0); else n_pass++;
    valid0 = 4'hF; rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (active0 !== 1'b0 || err0 !== 1'b0 || start0 !== 1'b0) $display("FAIL rstmid_state got active=%b err=%b start=%b want 0/0/0", active0, err0, start0); else n_pass++;
    n_checks++; if (txd0 !== 8'h00 || gid0 !== 2'd0 || ready0 !== 4'h0) $display("FAIL rstmid_regs got data=%h id=%0d ready=%b want 00/0/0000", txd0, gid0, ready0); else n_pass++;
    rst = 1'b0; #1;
    n_checks++; if (ready0 !== 4'b0001) $display("FAIL rstmid_next got %b want 0001", ready0); else n_pass++;
    @(negedge clk); valid0 = '0;
    n_checks++; if (start0 !== 1'b1 || gid0 !== 2'd0) $display("FAIL rstmid_restart got start=%b id=%0d want 1/0", start0, gid0); else n_pass++;
    $display("rst_mid: frame aborted, next grant port %0d", gid0);
    wait_idle0;
  endtask

  task automatic test_gap;
    int n; bit ok;
    do_reset;
    en1 = 4'hF; data1 = $urandom; valid1 = 4'hF;
    for (int f = 0; f < 3; f++) begin
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin #1; if (ready1 != 4'h0) ok = 1'b1; else @(negedge clk); end
      n_checks++; if (!ok || ready1 !== (4'b1 << f)) $display("FAIL gap_grant frame %0d got %b want idx %0d", f, ready1, f); else n_pass++;
      if (f == 2) break;
      @(negedge clk);
      n = 0; while (!busy_to1 && n < 20)  begin @(negedge clk); n++; end
      n = 0; while (busy_to1 && n < 100) begin @(negedge clk); n++; end
      n_checks++; if (busy_to1 !== 1'b0 || active1 !== 1'b1) $display("FAIL gap_frame got busy=%b active=%b want 0/1", busy_to1, active1); else n_pass++;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ready1 != 4'h0) break;
        n++;
        n_checks++; if (active1 !== 1'b1) $display("FAIL gap_active cyc %0d got %b want 1", n, active1); else n_pass++;
      end
      n_checks++; if (n !== 3) $display("FAIL gap_len got %0d want 3", n); else n_pass++;
      n_checks++; if (active1 !== 1'b0) $display("FAIL gap_idle got %b want 0", active1); else n_pass++;
      $display("gap: frame %0d port %0d then %0d gap cycles", f, gid1, n);
    end
    valid1 = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_round_robin;
    test_port_mask;
    test_random;
    test_busy_idle;
    test_timeout;
    test_rst_mid_frame;
    test_gap;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
